// File: rtl/mips_seq_pkg.sv
// Shared types and opcode constants for the MiniMIPS multi-cycle control sequencer.
package mips_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } seq_state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h8;
  localparam logic [3:0] OP_J     = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: jump, taken branch, or sequential increment (all mod 2^PC_W).
module pc_next_calc
  import mips_seq_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     ir,
  input  logic            take,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] seq_pc_s;
  logic [PC_W-1:0] br_off_s;

  assign seq_pc_s = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign br_off_s = {{(PC_W-6){ir[5]}}, ir[5:0]};

  // Select the successor PC from the latched opcode and branch outcome.
  always_comb begin
    next_pc = seq_pc_s;
    case (ir[15:12])
      OP_J: begin
        next_pc = {pc[PC_W-1:12], ir[11:0]};
      end
      OP_BEQ: begin
        if (take) begin
          next_pc = seq_pc_s + br_off_s;
        end else begin
          next_pc = seq_pc_s;
        end
      end
      default: begin
        next_pc = seq_pc_s;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer owning the MiniMIPS program counter.
// Define PC_SEQ_TIMEOUT_EN to enable the MEM watchdog that raises a sticky fault and halts.
module pc_sequencer
  import mips_seq_pkg::*;
#(
  parameter int unsigned     PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = {PC_W{1'b0}},
  parameter int unsigned     MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     instruction,
  input  logic            alu_zero,
  input  logic            mem_ack,
  output logic [PC_W-1:0] pc_address,
  output logic [15:0]     ir,
  output logic            mem_req,
  output logic            wb_en,
  output logic            busy,
  output logic            halted,
  output logic            fault
);

  seq_state_t      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] next_pc_s;
  logic [15:0]     ir_q, ir_d;
  logic            take_q, take_d;
  logic            mem_req_q, mem_req_d;
  logic            wb_en_q, wb_en_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;
  logic [3:0]      op_s;

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int unsigned WDOG_W = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(MEM_TIMEOUT - 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              fault_q, fault_d;
`endif

  assign op_s = ir_q[15:12];

  pc_next_calc #(
    .PC_W(PC_W)
  ) u_pc_next (
    .pc     (pc_q),
    .ir     (ir_q),
    .take   (take_q),
    .next_pc(next_pc_s)
  );

  // Next-state, datapath-register and registered-output decode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    take_d  = take_q;
`ifdef PC_SEQ_TIMEOUT_EN
    wdog_d  = wdog_q;
    fault_d = fault_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        ir_d    = instruction;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (op_s == OP_BEQ) begin
          take_d = alu_zero;
        end else begin
          take_d = take_q;
        end
        if (is_mem_op(op_s)) begin
          state_d = ST_MEM;
`ifdef PC_SEQ_TIMEOUT_EN
          wdog_d  = {WDOG_W{1'b0}};
`endif
        end else if (op_s == OP_HALT) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ST_WB;
        end
`ifdef PC_SEQ_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          state_d = ST_HALTED;
          fault_d = 1'b1;
        end else begin
          wdog_d = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
        end
`else
        else begin
          state_d = ST_MEM;
        end
`endif
      end
      ST_WB: begin
        // The PC moves only here, so pc_address is stable across the instruction.
        pc_d    = next_pc_s;
        state_d = ST_FETCH;
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_req_d = (state_d == ST_MEM);
    wb_en_d   = (state_d == ST_WB);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_HALTED);
    halted_d  = (state_d == ST_HALTED);
  end

  // State, PC, IR and output registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      take_q    <= 1'b0;
      mem_req_q <= 1'b0;
      wb_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      take_q    <= take_d;
      mem_req_q <= mem_req_d;
      wb_en_q   <= wb_en_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

`ifdef PC_SEQ_TIMEOUT_EN
  // MEM watchdog counter and sticky fault flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q  <= {WDOG_W{1'b0}};
      fault_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign pc_address = pc_q;
  assign ir         = ir_q;
  assign mem_req    = mem_req_q;
  assign wb_en      = wb_en_q;
  assign busy       = busy_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an instruction-level reference model predicts every write-back.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
  localparam int          TMO    = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] instruction;
  logic        alu_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] pc_address;
  logic [15:0] ir;
  logic        mem_req, wb_en, busy, halted, fault;

  pc_sequencer #(.PC_W(32), .RESET_PC(RST_PC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .instruction(instruction),
    .alu_zero(alu_zero), .mem_ack(mem_ack), .pc_address(pc_address), .ir(ir),
    .mem_req(mem_req), .wb_en(wb_en), .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] ir;
    logic [31:0] next_pc;
    int          lat;
    int          memc;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] imem [64];
  bit          zero_seq [256];
  int          dly_seq [256];
  int          checks = 0;
  int          failures = 0;
  bit          halt_exp;
  logic [31:0] halt_pc;

  assign instruction = imem[pc_address[5:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Memory/ALU responder: per-instruction alu_zero and ack delay; random ack noise outside MEM.
  initial begin
    int ins_idx = 0;
    int req_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) ins_idx = 0;
      else if (wb_en) ins_idx++;
      alu_zero = zero_seq[ins_idx & 255];
      if (mem_req) begin
        mem_ack = (req_cnt == dly_seq[ins_idx & 255]);
        req_cnt++;
      end else begin
        req_cnt = 0;
        mem_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: on each write-back pop the expected instruction and compare.
  initial begin
    int lat_cnt = 0;
    int mem_cnt = 0;
    bit pend = 0;
    logic [31:0] pend_pc;
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("next_pc", pc_address, pend_pc);
        pend = 0;
      end
      if (busy) lat_cnt++; else lat_cnt = 0;
      if (mem_req) mem_cnt++;
      if (wb_en) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wb actual_pc=%h expected=no_writeback", pc_address);
        end else begin
          e = sb_q.pop_front();
          chk("wb_pc", pc_address, e.pc);
          chk("wb_ir", {16'h0, ir}, {16'h0, e.ir});
          chk("latency", lat_cnt, e.lat);
          chk("mem_req_cycles", mem_cnt, e.memc);
          pend = 1;
          pend_pc = e.next_pc;
        end
        lat_cnt = 0;
        mem_cnt = 0;
      end
      if (!busy) mem_cnt = 0;
    end
  end

  // Instruction-level reference: walks the program and predicts each write-back.
  task automatic run_model(input int n);
    logic [31:0] pc;
    logic [15:0] w;
    int imm;
    exp_t e;
    pc = RST_PC;
    halt_exp = 0;
    for (int k = 0; k < n; k++) begin
      w = imem[pc[5:0]];
      if (w[15:12] == 4'hF) begin
        halt_exp = 1;
        halt_pc = pc;
        break;
      end
      e.pc = pc;
      e.ir = w;
      if (w[15:12] == 4'h4 || w[15:12] == 4'h5) begin
        e.memc = dly_seq[k] + 1;
        e.lat = 4 + dly_seq[k];
      end else begin
        e.memc = 0;
        e.lat = 3;
      end
      imm = int'(w[5:0]);
      if (imm > 31) imm = imm - 64;
      if (w[15:12] == 4'hC) e.next_pc = (pc & 32'hFFFF_F000) | 32'(w[11:0]);
      else if (w[15:12] == 4'h8 && zero_seq[k]) e.next_pc = pc + 32'd1 + 32'(imm);
      else e.next_pc = pc + 32'd1;
      sb_q.push_back(e);
      pc = e.next_pc;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) tick();
    chk("rst_pc", pc_address, RST_PC);
    chk("rst_ir", {16'h0, ir}, 32'h0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_no_start", busy, 1'b0);
  endtask

  task automatic run_phase(input int n);
    int cyc;
    do_reset();
    run_model(n);
    start = 1'b1;
    cyc = 0;
    while (sb_q.size() != 0 && cyc < n * 16) begin
      tick();
      cyc++;
    end
    chk("phase_drained", (cyc < n * 16), 1'b1);
    sb_q.delete();
    if (halt_exp) begin
      cyc = 0;
      while (!halted && cyc < 20) begin
        tick();
        cyc++;
      end
      chk("halted", halted, 1'b1);
      chk("halt_pc", pc_address, halt_pc);
      chk("halt_busy", busy, 1'b0);
      repeat (10) tick();
      chk("halt_sticky", halted, 1'b1);
      chk("halt_pc_hold", pc_address, halt_pc);
      chk("halt_fault", fault, 1'b0);
    end else begin
      tick();
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      zero_seq[i] = 1'($urandom_range(0, 1));
      dly_seq[i] = 0;
    end

    // Directed walk: wrap at top, BEQ backwards through 0, BEQ at 5 taken/not, J at 6.
    imem[6'h33] = 16'h4123;
    imem[6'h36] = 16'h5000;
    imem[6'h00] = 16'h803D;
    imem[6'h02] = 16'h5001;
    imem[6'h05] = 16'h803E;
    imem[6'h06] = 16'hC123;
    for (int i = 0; i < 256; i++) dly_seq[i] = 3;
    zero_seq[16] = 1'b1;
    zero_seq[19] = 1'b0;
    zero_seq[24] = 1'b1;
    zero_seq[26] = 1'b0;
    run_phase(34);

    // HALT at PC=2 with start held high.
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    imem[6'h3A] = 16'h4000;
    imem[6'h02] = 16'hF000;
    run_phase(40);

    // Randomized program.
    for (int i = 0; i < 64; i++) imem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    for (int i = 0; i < 256; i++) begin
      zero_seq[i] = 1'($urandom_range(0, 1));
      dly_seq[i] = $urandom_range(0, 6);
    end
    run_phase(200);

    // Memory never acknowledges: reset mid-MEM, then watchdog / indefinite wait.
    for (int i = 0; i < 64; i++) imem[i] = 16'h4000;
    for (int i = 0; i < 256; i++) dly_seq[i] = 1000000;
    do_reset();
    start = 1'b1;
    cyc = 0;
    while (!mem_req && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("mem_req_rise", mem_req, 1'b1);
    repeat (3) tick();
    chk("mem_req_held", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    chk("midmem_rst_pc", pc_address, RST_PC);
    chk("midmem_rst_mem_req", mem_req, 1'b0);
    chk("midmem_rst_busy", busy, 1'b0);
    chk("midmem_rst_ir", {16'h0, ir}, 32'h0);
    do_reset();
    start = 1'b1;
    cyc = 0;
    while (!mem_req && cyc < 10) begin
      tick();
      cyc++;
    end
    cyc = 0;
    while (mem_req && cyc < 40) begin
      tick();
      cyc++;
    end
`ifdef PC_SEQ_TIMEOUT_EN
    chk("timeout_cycles", cyc, TMO);
    chk("timeout_fault", fault, 1'b1);
    chk("timeout_halted", halted, 1'b1);
    chk("timeout_pc", pc_address, RST_PC);
    repeat (5) tick();
    chk("fault_sticky", fault, 1'b1);
`else
    chk("mem_wait_cycles", cyc, 40);
    chk("mem_wait_req", mem_req, 1'b1);
    chk("mem_wait_fault", fault, 1'b0);
    chk("mem_wait_halted", halted, 1'b0);
`endif
    rst = 1'b1;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
